// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
// Mode and FSM state encodings plus helpers.
package shift_pkg;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101
  } mode_t;

  localparam logic [2:0] M_RSV0 = 3'b110;
  localparam logic [2:0] M_RSV1 = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_shift(
    input logic [2:0] m
  );
    return (m == M_SHL) || (m == M_SHR) ||
           (m == M_ROL) || (m == M_ROR);
  endfunction

endpackage

// File: rtl/shift_core.sv
// Next-value function of the register.
// Shared by direct mode and burst engine.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] po,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] nxt
);

  // Select the new register value for the mode.
  always_comb begin
    nxt = po;
    case (mode)
      M_LOAD: nxt = pi;
      M_SHL:  nxt = {po[WIDTH-2:0], sin_r};
      M_SHR:  nxt = {sin_l, po[WIDTH-1:1]};
      M_ROL:  nxt = {po[WIDTH-2:0], po[WIDTH-1]};
      M_ROR:  nxt = {po[0], po[WIDTH-1:1]};
      default: nxt = po;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with burst engine.
// FSM, burst counter, latched mode, po register.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] po,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  mode_t            lmode_q;
  logic [WIDTH-1:0] po_q;
  logic [WIDTH-1:0] po_nxt;
  logic [2:0]       core_mode;
  logic             accept;

  assign accept = (state_q == IDLE) && start &&
                  is_shift(mode);

  // Mode fed to the core: live, latched or hold.
  always_comb begin
    core_mode = M_HOLD;
    unique case (state_q)
      IDLE:    if (!accept) core_mode = mode;
      RUN:     core_mode = lmode_q;
      default: core_mode = M_HOLD;
    endcase
  end

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .po    (po_q),
    .mode  (core_mode),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .pi    (pi),
    .nxt   (po_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (shamt != '0) state_d = RUN;
          else             state_d = DONE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Burst counter and latched shift mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      lmode_q <= M_HOLD;
    end else if (accept) begin
      cnt_q   <= shamt;
      lmode_q <= mode_t'(mode);
    end else if (state_q == RUN) begin
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  // Data register; core returns po on hold cycles.
  always_ff @(posedge clk) begin
    if (!reset) po_q <= '0;
    else        po_q <= po_nxt;
  end

  assign po     = po_q;
  assign sout_l = po_q[WIDTH-1];
  assign sout_r = po_q[0];

endmodule
